// File: rtl/bn_pkg.sv
// rtl/bn_pkg.sv - shared BN constants, read-side state type and element-slice helper
package bn_pkg;

    localparam int DATA_WIDTH = 16;

    localparam logic [DATA_WIDTH-1:0] FP16_ZERO    = 16'h0000;
    localparam logic [DATA_WIDTH-1:0] FP16_ONE     = 16'h3C00;
    localparam logic [DATA_WIDTH-1:0] FP16_QUARTER = 16'h3400;

    localparam int FP16_SIGN_BIT = DATA_WIDTH - 1;

    // Widest packed vector the slice helper accepts; narrower vectors are zero-extended.
    localparam int MAX_ELEMS = 16;
    localparam int MAX_VEC_W = DATA_WIDTH * MAX_ELEMS;

    typedef enum logic {
        RD_EMPTY  = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    function automatic logic [DATA_WIDTH-1:0] fp16_elem(input logic [MAX_VEC_W-1:0] vec,
                                                        input int k);
        return vec[DATA_WIDTH*k +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/bn_vec_slot_buf.sv
// rtl/bn_vec_slot_buf.sv - two-slot ping-pong vector buffer with pointers and occupancy count
module bn_vec_slot_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int SIZE       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH*SIZE-1:0] wr_data,
    input  logic                       rd_free,
    output logic [DATA_WIDTH*SIZE-1:0] rd_data_next,
    output logic [1:0]                 count,
    output logic [1:0]                 count_next
);

    logic [DATA_WIDTH*SIZE-1:0] slot [2];
    logic                       wr_ptr;
    logic                       rd_ptr;
    logic                       rd_ptr_next;

    always_comb begin
        count_next = count;
        if (wr_en && !rd_free) begin
            count_next = count + 2'd1;
        end else if (!wr_en && rd_free) begin
            count_next = count - 2'd1;
        end
    end

    assign rd_ptr_next = rd_ptr ^ rd_free;

    // Contents of the slot that will be read after this edge, forwarding a vector
    // written this edge so an empty buffer presents element 0 one cycle later.
    assign rd_data_next = (wr_en && (wr_ptr == rd_ptr_next)) ? wr_data : slot[rd_ptr_next];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            wr_ptr <= wr_ptr ^ wr_en;
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    // Slot data needs no reset: the count alone decides whether it is live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            slot[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/bn_vec_serializer.sv
// rtl/bn_vec_serializer.sv - packed BN vector to element stream serializer (optional BN_VEC_SER_RELU_EN)
module bn_vec_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int size       = 8,
    parameter int IDX_W      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH*size-1:0] vec_in,
    input  logic                       vec_valid,
    output logic                       vec_ready,
    output logic [DATA_WIDTH-1:0]      elem_out,
    output logic                       elem_valid,
    input  logic                       elem_ready,
    output logic [IDX_W-1:0]           elem_idx,
    output logic                       elem_last,
    output logic                       busy
);

    import bn_pkg::*;

    logic [1:0]                 count;
    logic [1:0]                 count_next;
    logic                       wr_en;
    logic                       xfer;
    logic                       rd_free;
    logic [DATA_WIDTH*size-1:0] rd_data_next;
    rd_state_t                  state;
    rd_state_t                  state_n;
    logic [IDX_W-1:0]           idx_n;
    logic [DATA_WIDTH-1:0]      elem_q;
    logic [DATA_WIDTH-1:0]      elem_n;

    assign vec_ready  = (count != 2'd2);
    assign busy       = (count != 2'd0);
    assign elem_valid = (state == RD_STREAM);
    assign elem_last  = (elem_idx == IDX_W'(size - 1));
    assign wr_en      = vec_valid && vec_ready;
    assign xfer       = elem_valid && elem_ready;
    assign rd_free    = xfer && elem_last;

    bn_vec_slot_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (size)
    ) u_slot_buf (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (vec_in),
        .rd_free      (rd_free),
        .rd_data_next (rd_data_next),
        .count        (count),
        .count_next   (count_next)
    );

    always_comb begin
        state_n = state;
        idx_n   = elem_idx;
        elem_n  = elem_q;
        case (state)
            RD_EMPTY: begin
                if (wr_en) begin
                    state_n = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (rd_free && (count_next == 2'd0)) begin
                    state_n = RD_EMPTY;
                end
            end
        endcase
        if (xfer) begin
            idx_n = elem_last ? '0 : elem_idx + 1'b1;
        end
        // Register the element that will be presented next; when empty, keep the last one.
        if (count_next != 2'd0) begin
            elem_n = fp16_elem(MAX_VEC_W'(rd_data_next), int'(idx_n));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RD_EMPTY;
            elem_idx <= '0;
            elem_q   <= FP16_ZERO;
        end else begin
            state    <= state_n;
            elem_idx <= idx_n;
            elem_q   <= elem_n;
        end
    end

`ifdef BN_VEC_SER_RELU_EN
    assign elem_out = elem_q[FP16_SIGN_BIT] ? FP16_ZERO : elem_q;
`else
    assign elem_out = elem_q;
`endif

endmodule

// File: tb/tb_bn_vec_serializer.sv
// tb/tb_bn_vec_serializer.sv - self-checking bench for bn_vec_serializer against a vector-queue model
module tb_bn_vec_serializer;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW*N-1:0] vec_in;
    logic            vec_valid;
    logic            vec_ready;
    logic [DW-1:0]   elem_out;
    logic            elem_valid;
    logic            elem_ready;
    logic [IW-1:0]   elem_idx;
    logic            elem_last;
    logic            busy;

    always #5 clk = ~clk;

    bn_vec_serializer #(
        .DATA_WIDTH (DW),
        .size       (N),
        .IDX_W      (IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vec_in     (vec_in),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .elem_out   (elem_out),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_idx   (elem_idx),
        .elem_last  (elem_last),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;

    // Model: queue of whole vectors (at most two) plus the index into the head vector.
    logic [DW*N-1:0] mq[$];
    int              m_idx    = 0;
    logic [DW-1:0]   last_exp = 16'h0000;
    int              beats    = 0;

    function automatic logic [DW-1:0] ref_elem(input logic [DW*N-1:0] v, input int k);
        logic [DW-1:0] e;
        e = v[DW*k +: DW];
`ifdef BN_VEC_SER_RELU_EN
        if (e[DW-1]) e = 16'h0000;
`endif
        return e;
    endfunction

    function automatic logic [DW*N-1:0] rand_vec();
        logic [DW*N-1:0] v;
        for (int k = 0; k < N; k++) v[DW*k +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check 1 time unit later, advance the model at the rising edge.
    task automatic step(input logic vv, input logic [DW*N-1:0] v, input logic er, output logic acc);
        logic [DW-1:0] exp_e;
        vec_valid  = vv;
        vec_in     = v;
        elem_ready = er;
        #1;
        check("vec_ready", 32'(vec_ready), 32'(mq.size() < 2));
        check("elem_valid", 32'(elem_valid), 32'(mq.size() > 0));
        check("busy", 32'(busy), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            exp_e = ref_elem(mq[0], m_idx);
            check("elem_out", 32'(elem_out), 32'(exp_e));
            check("elem_idx", 32'(elem_idx), 32'(m_idx));
            check("elem_last", 32'(elem_last), 32'(m_idx == N - 1));
            last_exp = exp_e;
        end else begin
            check("elem_out_hold", 32'(elem_out), 32'(last_exp));
        end
        acc = vv && (mq.size() < 2);
        @(posedge clk);
        if (mq.size() > 0 && er) begin
            beats++;
            m_idx++;
            if (m_idx == N) begin
                m_idx = 0;
                void'(mq.pop_front());
            end
        end
        if (acc) mq.push_back(v);
        @(negedge clk);
    endtask

    logic            acc;
    logic [DW*N-1:0] vecs [3];
    int              vi;

    initial begin
        reset      = 1'b1;
        vec_valid  = 1'b0;
        vec_in     = '0;
        elem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_vec_ready", 32'(vec_ready), 32'd1);
        check("rst_elem_valid", 32'(elem_valid), 32'd0);
        check("rst_elem_out", 32'(elem_out), 32'd0);
        check("rst_elem_idx", 32'(elem_idx), 32'd0);
        check("rst_elem_last", 32'(elem_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single vector, element 0 first.
        step(1'b1, {16'h4500, 16'h4400, 16'h4200, 16'h4200, 16'h4500, 16'h4400, 16'h4200, 16'h4200}, 1'b1, acc);
        for (int c = 0; c < 10; c++) step(1'b0, '0, 1'b1, acc);
        check("single_beats", 32'(beats), 32'd8);

        // Back-to-back: three vectors with vec_valid held high.
        beats = 0;
        for (int i = 0; i < 3; i++) vecs[i] = rand_vec();
        vi = 0;
        for (int c = 0; c < 40; c++) begin
            step(vi < 3, vecs[vi < 3 ? vi : 0], 1'b1, acc);
            if (acc) vi++;
        end
        check("b2b_accepted", 32'(vi), 32'd3);
        check("b2b_beats", 32'(beats), 32'd24);

        // Backpressure pattern 1,0,0 repeating on one vector.
        beats = 0;
        step(1'b1, rand_vec(), 1'b0, acc);
        for (int c = 0; c < 30; c++) step(1'b0, '0, (c % 3) == 0, acc);
        check("bp_beats", 32'(beats), 32'd8);

        // Full buffer: hold downstream, offer three vectors, then release.
        beats = 0;
        for (int i = 0; i < 3; i++) vecs[i] = rand_vec();
        vi = 0;
        for (int c = 0; c < 6; c++) begin
            step(vi < 3, vecs[vi < 3 ? vi : 0], 1'b0, acc);
            if (acc) vi++;
        end
        check("full_accepted", 32'(vi), 32'd2);
        for (int c = 0; c < 30; c++) begin
            step(vi < 3, vecs[vi < 3 ? vi : 0], 1'b1, acc);
            if (acc) vi++;
        end
        check("full_beats", 32'(beats), 32'd24);

        // Sign handling: element 0 = -1.0, element 1 = -0, element 2 = 1.0.
        step(1'b1, {16'h4500, 16'h4400, 16'h4200, 16'h4200, 16'h4500, 16'h3C00, 16'h8000, 16'hBC00}, 1'b1, acc);
        for (int c = 0; c < 9; c++) step(1'b0, '0, 1'b1, acc);

        // Randomised traffic.
        beats = 0;
        vecs[0] = rand_vec();
        for (int c = 0; c < 300; c++) begin
            step(1'($urandom_range(0, 1)), vecs[0], 1'($urandom_range(0, 3) != 0), acc);
            if (acc) vecs[0] = rand_vec();
        end
        for (int c = 0; c < 20; c++) step(1'b0, '0, 1'b1, acc);
        check("rand_drained", 32'(mq.size()), 32'd0);

        // Reset mid-stream at elem_idx 3 with the second slot loaded.
        step(1'b1, rand_vec(), 1'b0, acc);
        step(1'b1, rand_vec(), 1'b0, acc);
        for (int c = 0; c < 3; c++) step(1'b0, '0, 1'b1, acc);
        check("pre_rst_idx", 32'(elem_idx), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_elem_valid", 32'(elem_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_vec_ready", 32'(vec_ready), 32'd1);
        check("mid_rst_elem_out", 32'(elem_out), 32'd0);
        check("mid_rst_elem_idx", 32'(elem_idx), 32'd0);
        mq.delete();
        m_idx    = 0;
        last_exp = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) step(1'b0, '0, 1'b1, acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
